// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore control FSM for a multicycle ARM-style datapath with an FPU path.
// Ports:
//   clk, reset      - clock and synchronous active-low reset
//   Instr[19:0]     - instruction bits [31:12] (Cond, Op, Funct, Rn, Rd)
//   ALUFlags[3:0]   - NZCV produced by the datapath ALU
//   PCWrite, MemWrite, RegWrite, IRWrite, FPUWrite - write enables (condition gated)
//   AdrSrc, RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl - datapath mux/ALU selects
module multicycle_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        FPUWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [2:0]  ALUControl
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3,
        MEMWB = 4'd4, MEMWRITE = 4'd5, EXECUTER = 4'd6, EXECUTEI = 4'd7,
        ALUWB = 4'd8, BRANCH = 4'd9, EXECUTEF = 4'd10, FPUWB = 4'd11
    } state_t;
    state_t      state_q, s;
    logic [3:0]  flags_q, cond, rd;
    logic [1:0]  op, flag_w;
    logic [5:0]  funct;
    logic        is_add, is_sub, is_and, is_orr, is_cmp, dp_valid, cond_ex, exec;
    logic        next_pc, reg_w, mem_w, fpu_w, ir_w, branch, pcs;
    logic [2:0]  alu_dp;
    logic        unused_rn;
    assign cond      = Instr[19:16];
    assign op        = Instr[15:14];
    assign funct     = Instr[13:8];
    assign rd        = Instr[3:0];
    assign unused_rn = ^Instr[7:4];
    assign is_add   = funct[4:1] == 4'b0100;
    assign is_sub   = funct[4:1] == 4'b0010;
    assign is_and   = funct[4:1] == 4'b0000;
    assign is_orr   = funct[4:1] == 4'b1100;
    assign is_cmp   = funct[4:1] == 4'b1010;
    assign dp_valid = is_add | is_sub | is_and | is_orr;
    assign alu_dp   = (is_sub | is_cmp) ? 3'b001 : is_and ? 3'b010 : is_orr ? 3'b011 : 3'b000;
    assign flag_w   = {funct[0], funct[0] & (is_add | is_sub | is_cmp)};
    assign exec     = (state_q == EXECUTER) || (state_q == EXECUTEI);
    assign ImmSrc   = op;
    assign RegSrc   = {op == 2'b01, op == 2'b10};
    // Standard ARM condition evaluation against the stored NZCV.
    always_comb begin
        case (cond)
            4'b0000: cond_ex = flags_q[2];
            4'b0001: cond_ex = ~flags_q[2];
            4'b0010: cond_ex = flags_q[1];
            4'b0011: cond_ex = ~flags_q[1];
            4'b0100: cond_ex = flags_q[3];
            4'b0101: cond_ex = ~flags_q[3];
            4'b0110: cond_ex = flags_q[0];
            4'b0111: cond_ex = ~flags_q[0];
            4'b1000: cond_ex = flags_q[1] & ~flags_q[2];
            4'b1001: cond_ex = ~flags_q[1] | flags_q[2];
            4'b1010: cond_ex = flags_q[3] == flags_q[0];
            4'b1011: cond_ex = flags_q[3] != flags_q[0];
            4'b1100: cond_ex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
            4'b1101: cond_ex = flags_q[2] | (flags_q[3] != flags_q[0]);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= FETCH;
            flags_q <= 4'b0000;
        end else begin
            if (exec && cond_ex) begin
                if (flag_w[1]) flags_q[3:2] <= ALUFlags[3:2];
                if (flag_w[0]) flags_q[1:0] <= ALUFlags[1:0];
            end
            case (state_q)
                FETCH:    state_q <= DECODE;
                DECODE:   state_q <= op == 2'b01 ? MEMADR :
                                     op == 2'b10 ? BRANCH :
                                     op == 2'b11 ? EXECUTEF :
                                     funct[5] ? EXECUTEI : EXECUTER;
                MEMADR:   state_q <= funct[0] ? MEMREAD : MEMWRITE;
                MEMREAD:  state_q <= MEMWB;
                EXECUTER: state_q <= ALUWB;
                EXECUTEI: state_q <= ALUWB;
                EXECUTEF: state_q <= FPUWB;
                default:  state_q <= FETCH;
            endcase
        end
    end
    // While reset is held, decode as FETCH so the muxes show FETCH values.
    assign s = reset ? state_q : FETCH;
    always_comb begin
        {next_pc, reg_w, mem_w, fpu_w, ir_w, branch, AdrSrc} = '0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = 3'b000;
        case (s)
            FETCH:    begin ir_w = 1'b1; next_pc = 1'b1; ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10; end
            DECODE:   begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; ResultSrc = 2'b10; end
            MEMADR:   ALUSrcB = 2'b01;
            MEMREAD:  AdrSrc = 1'b1;
            MEMWRITE: begin AdrSrc = 1'b1; mem_w = 1'b1; end
            MEMWB:    begin ResultSrc = 2'b01; reg_w = 1'b1; end
            EXECUTER: ALUControl = alu_dp;
            EXECUTEI: begin ALUSrcB = 2'b01; ALUControl = alu_dp; end
            ALUWB:    reg_w = dp_valid;
            BRANCH:   begin ALUSrcB = 2'b01; ResultSrc = 2'b10; branch = 1'b1; end
            FPUWB:    fpu_w = 1'b1;
            default:  ;
        endcase
    end
    assign pcs      = branch | (reg_w & (rd == 4'b1111));
    assign PCWrite  = reset & (next_pc | (pcs & cond_ex));
    assign RegWrite = reset & reg_w & cond_ex;
    assign MemWrite = reset & mem_w & cond_ex;
    assign FPUWrite = reset & fpu_w & cond_ex;
    assign IRWrite  = reset & ir_w;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed scoreboard bench for the multicycle control FSM.
module tb_multicycle_ctrl;
    logic        clk, reset;
    logic [19:0] instr;
    logic [3:0]  alu_flags;
    logic        PCWrite, MemWrite, RegWrite, IRWrite, FPUWrite, AdrSrc;
    logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic [2:0]  ALUControl;
    typedef struct {
        string       tag;
        logic [18:0] v;
    } exp_t;
    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .Instr(instr), .ALUFlags(alu_flags),
        .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
        .FPUWrite(FPUWrite), .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl)
    );
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    // we = {PCWrite, MemWrite, RegWrite, IRWrite, FPUWrite}; RegSrc/ImmSrc follow from Op.
    task automatic chk(input string tag, input logic [4:0] we, input logic adr,
                       input logic [1:0] a, input logic [1:0] b, input logic [1:0] r,
                       input logic [2:0] alu);
        exp_t e;
        logic [18:0] obs;
        e.tag = tag;
        e.v = {we, adr, instr[15:14] == 2'b01, instr[15:14] == 2'b10, a, b, r, instr[15:14], alu};
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        obs = {PCWrite, MemWrite, RegWrite, IRWrite, FPUWrite, AdrSrc, RegSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl};
        checks++;
        assert (obs === e.v) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.v);
        end
        @(negedge clk);
    endtask
    task automatic fetch_decode(input string n);
        chk({n, ".fetch"},  5'b10010, 1'b0, 2'b01, 2'b10, 2'b10, 3'b000);
        chk({n, ".decode"}, 5'b00000, 1'b0, 2'b01, 2'b10, 2'b10, 3'b000);
    endtask
    initial begin
        reset = 1'b0;
        instr = 20'h0;
        alu_flags = 4'h0;
        @(negedge clk);
        chk("reset", 5'b00000, 1'b0, 2'b01, 2'b10, 2'b10, 3'b000);
        reset = 1'b1;
        // LDR R0,[R1,#..]
        instr = 20'hE5910;
        fetch_decode("ldr");
        chk("ldr.memadr",  5'b00000, 1'b0, 2'b00, 2'b01, 2'b00, 3'b000);
        chk("ldr.memread", 5'b00000, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000);
        chk("ldr.memwb",   5'b00100, 1'b0, 2'b00, 2'b00, 2'b01, 3'b000);
        // SUBS R1,R1,#1 with Z result
        instr = 20'hE2511;
        alu_flags = 4'b0100;
        fetch_decode("subs");
        chk("subs.execi", 5'b00000, 1'b0, 2'b00, 2'b01, 2'b00, 3'b001);
        chk("subs.aluwb", 5'b00100, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000);
        alu_flags = 4'b0000;
        instr = 20'h0A000;
        fetch_decode("beq");
        chk("beq.branch", 5'b10000, 1'b0, 2'b00, 2'b01, 2'b10, 3'b000);
        instr = 20'h1A000;
        fetch_decode("bne");
        chk("bne.branch", 5'b00000, 1'b0, 2'b00, 2'b01, 2'b10, 3'b000);
        // CMP R0,R1 -> N=1, Z cleared
        instr = 20'hE1500;
        alu_flags = 4'b1000;
        fetch_decode("cmp");
        chk("cmp.execr", 5'b00000, 1'b0, 2'b00, 2'b00, 2'b00, 3'b001);
        chk("cmp.aluwb", 5'b00000, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000);
        alu_flags = 4'b0000;
        instr = 20'h4A000;
        fetch_decode("bmi");
        chk("bmi.branch", 5'b10000, 1'b0, 2'b00, 2'b01, 2'b10, 3'b000);
        // STREQ with Z=0: write suppressed, 4-cycle latency
        instr = 20'h05810;
        fetch_decode("streq");
        chk("streq.memadr", 5'b00000, 1'b0, 2'b00, 2'b01, 2'b00, 3'b000);
        chk("streq.memwr",  5'b00000, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000);
        // ADD R15,R0,R1 without S: flags must not change
        instr = 20'hE080F;
        alu_flags = 4'b0100;
        fetch_decode("addpc");
        chk("addpc.execr", 5'b00000, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000);
        chk("addpc.aluwb", 5'b10100, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000);
        alu_flags = 4'b0000;
        instr = 20'h0A000;
        fetch_decode("beq2");
        chk("beq2.branch", 5'b00000, 1'b0, 2'b00, 2'b01, 2'b10, 3'b000);
        // ORR R2,R0,#imm
        instr = 20'hE3802;
        fetch_decode("orr");
        chk("orr.execi", 5'b00000, 1'b0, 2'b00, 2'b01, 2'b00, 3'b011);
        chk("orr.aluwb", 5'b00100, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000);
        // FPU op
        instr = 20'hEC000;
        fetch_decode("fpu");
        chk("fpu.execf", 5'b00000, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000);
        chk("fpu.fpuwb", 5'b00001, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000);
        // STR aborted by reset in MEMWRITE
        instr = 20'hE5810;
        fetch_decode("strrst");
        chk("strrst.memadr", 5'b00000, 1'b0, 2'b00, 2'b01, 2'b00, 3'b000);
        reset = 1'b0;
        chk("strrst.memwr", 5'b00000, 1'b0, 2'b01, 2'b10, 2'b10, 3'b000);
        reset = 1'b1;
        fetch_decode("after_rst");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
